// File: rtl/pipe_front_regs.sv
// rtl/pipe_front_regs.sv - fetch PC, IF/ID and ID/EX pipeline registers with stall/flush counters
module pipe_front_regs (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        stallF,
    input  logic        stallD,
    input  logic        flushE,
    input  logic        pcsrcD,
    input  logic        jumpD,
    input  logic [31:0] pcbranchD,
    input  logic [31:0] pcjumpD,
    input  logic [31:0] instrF,
    output logic [31:0] pcF,
    output logic [31:0] instrD,
    output logic [31:0] pcplus4D,
    output logic        validD,
    input  logic [31:0] rd1D,
    input  logic [31:0] rd2D,
    input  logic [31:0] signimmD,
    input  logic [4:0]  rsD,
    input  logic [4:0]  rtD,
    input  logic [4:0]  rdD,
    input  logic [7:0]  ctrlD,
    output logic [31:0] rd1E,
    output logic [31:0] rd2E,
    output logic [31:0] signimmE,
    output logic [4:0]  rsE,
    output logic [4:0]  rtE,
    output logic [4:0]  rdE,
    output logic [7:0]  ctrlE,
    output logic        validE,
    output logic [31:0] stall_cnt,
    output logic [31:0] flush_cnt
);

    logic [31:0] r_pc;
    logic [31:0] r_instr_d;
    logic [31:0] r_pcplus4_d;
    logic        r_valid_d;
    logic [31:0] r_rd1_e;
    logic [31:0] r_rd2_e;
    logic [31:0] r_signimm_e;
    logic [4:0]  r_rs_e;
    logic [4:0]  r_rt_e;
    logic [4:0]  r_rd_e;
    logic [7:0]  r_ctrl_e;
    logic        r_valid_e;
    logic [31:0] r_stall_cnt;
    logic [31:0] r_flush_cnt;

    logic [31:0] w_pcplus4_f;
    logic        w_redirect;
    logic        w_squash;
    logic [31:0] w_pc_next;

    assign w_pcplus4_f = r_pc + 32'd4;
    assign w_redirect  = pcsrcD | jumpD;
    // A stalled IF/ID keeps its instruction, so a redirect only squashes when IF/ID moves.
    assign w_squash    = ~stallD & w_redirect;

    always_comb begin
        w_pc_next = w_pcplus4_f;
        if (jumpD)       w_pc_next = pcjumpD;
        else if (pcsrcD) w_pc_next = pcbranchD;
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_pc <= 32'd0;
        end else if (!stallF) begin
            r_pc <= w_pc_next;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || w_squash) begin
            r_instr_d   <= 32'd0;
            r_pcplus4_d <= 32'd0;
            r_valid_d   <= 1'b0;
        end else if (!stallD) begin
            r_instr_d   <= instrF;
            r_pcplus4_d <= w_pcplus4_f;
            r_valid_d   <= 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n || flushE) begin
            r_rd1_e     <= 32'd0;
            r_rd2_e     <= 32'd0;
            r_signimm_e <= 32'd0;
            r_rs_e      <= 5'd0;
            r_rt_e      <= 5'd0;
            r_rd_e      <= 5'd0;
            r_ctrl_e    <= 8'd0;
            r_valid_e   <= 1'b0;
        end else begin
            r_rd1_e     <= rd1D;
            r_rd2_e     <= rd2D;
            r_signimm_e <= signimmD;
            r_rs_e      <= rsD;
            r_rt_e      <= rtD;
            r_rd_e      <= rdD;
            r_ctrl_e    <= ctrlD;
            r_valid_e   <= r_valid_d;
        end
    end

    // Saturating counters: a cycle with both a bubble and a squash counts once.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            r_stall_cnt <= 32'd0;
            r_flush_cnt <= 32'd0;
        end else begin
            if (stallF && (r_stall_cnt != 32'hFFFF_FFFF))
                r_stall_cnt <= r_stall_cnt + 32'd1;
            if ((flushE || w_squash) && (r_flush_cnt != 32'hFFFF_FFFF))
                r_flush_cnt <= r_flush_cnt + 32'd1;
        end
    end

    assign pcF       = r_pc;
    assign instrD    = r_instr_d;
    assign pcplus4D  = r_pcplus4_d;
    assign validD    = r_valid_d;
    assign rd1E      = r_rd1_e;
    assign rd2E      = r_rd2_e;
    assign signimmE  = r_signimm_e;
    assign rsE       = r_rs_e;
    assign rtE       = r_rt_e;
    assign rdE       = r_rd_e;
    assign ctrlE     = r_ctrl_e;
    assign validE    = r_valid_e;
    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;

endmodule

// File: tb/tb_pipe_front_regs.sv
// tb/tb_pipe_front_regs.sv - directed vector table, corner sequences and randomized model check
module tb_pipe_front_regs;

    logic        clk = 1'b0;
    logic        rst_n, stallF, stallD, flushE, pcsrcD, jumpD;
    logic [31:0] pcbranchD, pcjumpD, instrF;
    logic [31:0] pcF, instrD, pcplus4D;
    logic        validD;
    logic [31:0] rd1D, rd2D, signimmD;
    logic [4:0]  rsD, rtD, rdD;
    logic [7:0]  ctrlD;
    logic [31:0] rd1E, rd2E, signimmE;
    logic [4:0]  rsE, rtE, rdE;
    logic [7:0]  ctrlE;
    logic        validE;
    logic [31:0] stall_cnt, flush_cnt;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    pipe_front_regs dut (
        .clk(clk), .rst_n(rst_n), .stallF(stallF), .stallD(stallD), .flushE(flushE),
        .pcsrcD(pcsrcD), .jumpD(jumpD), .pcbranchD(pcbranchD), .pcjumpD(pcjumpD),
        .instrF(instrF), .pcF(pcF), .instrD(instrD), .pcplus4D(pcplus4D), .validD(validD),
        .rd1D(rd1D), .rd2D(rd2D), .signimmD(signimmD), .rsD(rsD), .rtD(rtD), .rdD(rdD),
        .ctrlD(ctrlD), .rd1E(rd1E), .rd2E(rd2E), .signimmE(signimmE), .rsE(rsE), .rtE(rtE),
        .rdE(rdE), .ctrlE(ctrlE), .validE(validE), .stall_cnt(stall_cnt), .flush_cnt(flush_cnt)
    );

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%08h expected 0x%08h (t=%0t)", name, act, exp, $time);
        end
    endtask

    typedef struct {
        bit          rst_n, stall_f, stall_d, flush_e, pcsrc, jump;
        logic [31:0] pcbranch, pcjump, instr;
        logic [31:0] e_pc, e_instr_d, e_pcplus4_d;
        bit          e_valid_d, e_valid_e;
        logic [7:0]  e_ctrl_e;
        logic [31:0] e_stall, e_flush;
    } vec_t;

    vec_t vecs[14];

    // Behavioural reference: architectural state advanced by the written rules.
    typedef struct {
        logic [31:0] pc, instr_d, pcplus4_d;
        bit          valid_d;
        logic [31:0] rd1, rd2, imm;
        logic [4:0]  rs, rt, rd;
        logic [7:0]  ctrl;
        bit          valid_e;
        longint      stall_n, flush_n;
    } model_t;

    model_t m;

    function automatic longint sat_inc(input longint v);
        return (v >= 64'hFFFF_FFFF) ? 64'hFFFF_FFFF : v + 1;
    endfunction

    task automatic model_step();
        model_t n;
        bit squash;
        n = m;
        if (!rst_n) begin
            n = '{default: 0};
        end else begin
            squash = !stallD && (pcsrcD || jumpD);
            if (!stallF)
                n.pc = jumpD ? pcjumpD : (pcsrcD ? pcbranchD : m.pc + 32'd4);
            if (squash) begin
                n.instr_d = 0; n.pcplus4_d = 0; n.valid_d = 0;
            end else if (!stallD) begin
                n.instr_d = instrF; n.pcplus4_d = m.pc + 32'd4; n.valid_d = 1;
            end
            if (flushE) begin
                n.rd1 = 0; n.rd2 = 0; n.imm = 0; n.rs = 0; n.rt = 0; n.rd = 0;
                n.ctrl = 0; n.valid_e = 0;
            end else begin
                n.rd1 = rd1D; n.rd2 = rd2D; n.imm = signimmD; n.rs = rsD; n.rt = rtD;
                n.rd = rdD; n.ctrl = ctrlD; n.valid_e = m.valid_d;
            end
            if (stallF)           n.stall_n = sat_inc(m.stall_n);
            if (flushE || squash) n.flush_n = sat_inc(m.flush_n);
        end
        m = n;
    endtask

    task automatic check_model(input string tag);
        chk({tag, ".pcF"},      pcF,      m.pc);
        chk({tag, ".instrD"},   instrD,   m.instr_d);
        chk({tag, ".pcplus4D"}, pcplus4D, m.pcplus4_d);
        chk({tag, ".validD"},   {31'd0, validD}, {31'd0, m.valid_d});
        chk({tag, ".rd1E"},     rd1E,     m.rd1);
        chk({tag, ".rd2E"},     rd2E,     m.rd2);
        chk({tag, ".signimmE"}, signimmE, m.imm);
        chk({tag, ".regsE"},    {17'd0, rsE, rtE, rdE}, {17'd0, m.rs, m.rt, m.rd});
        chk({tag, ".ctrlE"},    {24'd0, ctrlE}, {24'd0, m.ctrl});
        chk({tag, ".validE"},   {31'd0, validE}, {31'd0, m.valid_e});
        chk({tag, ".stall_cnt"}, stall_cnt, m.stall_n[31:0]);
        chk({tag, ".flush_cnt"}, flush_cnt, m.flush_n[31:0]);
    endtask

    task automatic drive(input bit r, input bit sf, input bit sd, input bit fe,
                         input bit ps, input bit jp, input logic [31:0] pb,
                         input logic [31:0] pj, input logic [31:0] ins);
        @(negedge clk);
        rst_n = r; stallF = sf; stallD = sd; flushE = fe; pcsrcD = ps; jumpD = jp;
        pcbranchD = pb; pcjumpD = pj; instrF = ins;
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mk(input bit r, input bit sf, input bit sd, input bit fe,
                                input bit ps, input bit jp, input logic [31:0] pb,
                                input logic [31:0] pj, input logic [31:0] ins,
                                input logic [31:0] epc, input logic [31:0] eid,
                                input logic [31:0] ep4, input bit evd, input bit eve,
                                input logic [7:0] ec, input logic [31:0] es,
                                input logic [31:0] ef);
        vec_t v;
        v = '{r, sf, sd, fe, ps, jp, pb, pj, ins, epc, eid, ep4, evd, eve, ec, es, ef};
        return v;
    endfunction

    initial begin
        rst_n = 0; stallF = 0; stallD = 0; flushE = 0; pcsrcD = 0; jumpD = 0;
        pcbranchD = 0; pcjumpD = 0; instrF = 0;
        rd1D = 32'h1111_0001; rd2D = 32'h2222_0002; signimmD = 32'hFFFF_FFF0;
        rsD = 5'd3; rtD = 5'd7; rdD = 5'd9; ctrlD = 8'hA5;

        //            rst sF sD fE ps jp  pcbranch      pcjump        instrF          pcF           instrD        pcplus4D      vD vE ctrlE   stall flush
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0001, 32'h0,        32'h0,        32'h0,        0, 0, 8'h00, 0, 0);
        vecs[1]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0001, 32'h4,        32'h2008_0001, 32'h4,       1, 0, 8'hA5, 0, 0);
        vecs[2]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0002, 32'h8,        32'h2008_0002, 32'h8,       1, 1, 8'hA5, 0, 0);
        vecs[3]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0003, 32'hC,        32'h2008_0003, 32'hC,       1, 1, 8'hA5, 0, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0004, 32'h10,       32'h2008_0004, 32'h10,      1, 1, 8'hA5, 0, 0);
        vecs[5]  = mk(1, 1, 1, 1, 0, 0, 32'h0,        32'h0,        32'h2008_0005, 32'h10,       32'h2008_0004, 32'h10,      1, 0, 8'h00, 1, 1);
        vecs[6]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0005, 32'h14,       32'h2008_0005, 32'h14,      1, 1, 8'hA5, 1, 1);
        vecs[7]  = mk(1, 0, 0, 0, 1, 0, 32'h40,       32'h0,        32'h2008_0006, 32'h40,       32'h0,        32'h0,        0, 1, 8'hA5, 1, 2);
        vecs[8]  = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0007, 32'h44,       32'h2008_0007, 32'h44,      1, 0, 8'hA5, 1, 2);
        vecs[9]  = mk(1, 0, 0, 0, 1, 1, 32'h40,       32'h80,       32'h2008_0009, 32'h80,       32'h0,        32'h0,        0, 1, 8'hA5, 1, 3);
        vecs[10] = mk(1, 0, 0, 0, 0, 0, 32'h0,        32'h0,        32'h2008_0008, 32'h84,       32'h2008_0008, 32'h84,      1, 0, 8'hA5, 1, 3);
        vecs[11] = mk(1, 1, 1, 0, 1, 0, 32'h40,       32'h0,        32'h2008_00FF, 32'h84,       32'h2008_0008, 32'h84,      1, 1, 8'hA5, 2, 3);
        vecs[12] = mk(1, 0, 0, 1, 0, 0, 32'h0,        32'h0,        32'h2008_0009, 32'h88,       32'h2008_0009, 32'h88,      1, 0, 8'h00, 2, 4);
        vecs[13] = mk(0, 1, 1, 0, 1, 1, 32'h40,       32'h80,       32'h2008_000A, 32'h0,        32'h0,        32'h0,        0, 0, 8'h00, 0, 0);

        for (int i = 0; i < 14; i++) begin
            drive(vecs[i].rst_n, vecs[i].stall_f, vecs[i].stall_d, vecs[i].flush_e,
                  vecs[i].pcsrc, vecs[i].jump, vecs[i].pcbranch, vecs[i].pcjump, vecs[i].instr);
            chk($sformatf("vec%0d.pcF", i),      pcF,      vecs[i].e_pc);
            chk($sformatf("vec%0d.instrD", i),   instrD,   vecs[i].e_instr_d);
            chk($sformatf("vec%0d.pcplus4D", i), pcplus4D, vecs[i].e_pcplus4_d);
            chk($sformatf("vec%0d.validD", i),   {31'd0, validD}, {31'd0, vecs[i].e_valid_d});
            chk($sformatf("vec%0d.validE", i),   {31'd0, validE}, {31'd0, vecs[i].e_valid_e});
            chk($sformatf("vec%0d.ctrlE", i),    {24'd0, ctrlE},  {24'd0, vecs[i].e_ctrl_e});
            chk($sformatf("vec%0d.stall_cnt", i), stall_cnt, vecs[i].e_stall);
            chk($sformatf("vec%0d.flush_cnt", i), flush_cnt, vecs[i].e_flush);
        end

        // Counter saturation: preload near the top, then stall and bubble for three cycles.
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        @(negedge clk);
        force dut.r_stall_cnt = 32'hFFFF_FFFE;
        force dut.r_flush_cnt = 32'hFFFF_FFFE;
        #1;
        release dut.r_stall_cnt;
        release dut.r_flush_cnt;
        for (int k = 0; k < 3; k++) begin
            drive(1, 1, 1, 1, 0, 0, 0, 0, 32'h0);
            chk($sformatf("sat%0d.stall_cnt", k), stall_cnt, 32'hFFFF_FFFF);
            chk($sformatf("sat%0d.flush_cnt", k), flush_cnt, 32'hFFFF_FFFF);
        end

        // Reset during a stall with saturated counters clears everything.
        drive(0, 1, 1, 0, 1, 0, 32'h40, 0, 32'h1234_5678);
        chk("rststall.pcF", pcF, 32'h0);
        chk("rststall.stall_cnt", stall_cnt, 32'h0);
        chk("rststall.flush_cnt", flush_cnt, 32'h0);
        chk("rststall.validD", {31'd0, validD}, 32'h0);

        // PC wrap: jump to the last word, then a plain fetch wraps to zero.
        drive(1, 0, 0, 0, 0, 1, 0, 32'hFFFF_FFFC, 32'h0);
        chk("wrap.jump_pcF", pcF, 32'hFFFF_FFFC);
        drive(1, 0, 0, 0, 0, 0, 0, 0, 32'hCAFE_0001);
        chk("wrap.pcF", pcF, 32'h0);
        chk("wrap.pcplus4D", pcplus4D, 32'h0);
        chk("wrap.instrD", instrD, 32'hCAFE_0001);

        // Randomized run against the reference model, starting from reset.
        drive(0, 0, 0, 0, 0, 0, 0, 0, 32'h0);
        m = '{default: 0};
        check_model("rnd_rst");
        for (int c = 0; c < 3000; c++) begin
            @(negedge clk);
            rst_n     = ($urandom_range(0, 63) != 0);
            stallF    = ($urandom_range(0, 3) == 0);
            stallD    = ($urandom_range(0, 4) == 0) ? ~stallF : stallF;
            flushE    = ($urandom_range(0, 3) == 0);
            pcsrcD    = ($urandom_range(0, 4) == 0);
            jumpD     = ($urandom_range(0, 6) == 0);
            pcbranchD = {$urandom} & 32'hFFFF_FFFC;
            pcjumpD   = ($urandom_range(0, 7) == 0) ? 32'hFFFF_FFF8 : ({$urandom} & 32'hFFFF_FFFC);
            instrF    = $urandom;
            rd1D      = $urandom;
            rd2D      = $urandom;
            signimmD  = $urandom;
            rsD       = 5'($urandom);
            rtD       = 5'($urandom);
            rdD       = 5'($urandom);
            ctrlD     = 8'($urandom);
            model_step();
            @(posedge clk);
            #1;
            check_model($sformatf("rnd%0d", c));
        end

        $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
        $finish;
    end

endmodule
